// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO divide unit.
// State encoding, move-from bit positions and the divide-by-zero quotient fill.
package hilo_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam int MF_ACTIVE = 1;
  localparam int MF_HI     = 0;

  localparam logic DIV0_LO_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift, trial-subtract, set quotient bit.
module div_step
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] rem_wide;
  logic           ge;

  // The extra top bit keeps the trial compare exact even if the shift carries out.
  always_comb begin
    rem_wide = {rem_in, q_in[WIDTH-1]};
    ge       = (rem_wide >= {1'b0, divisor});
    q_out    = {q_in[WIDTH-2:0], ge};
    rem_out  = ge ? (rem_wide[WIDTH-1:0] - divisor) : rem_wide[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle signed divider owning the HI/LO registers, with stall request for move-from reads.
// Optional macro HILO_MT_EN adds the mt port for move-to writes of HI/LO while idle.
module hilo_div_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       mf,
`ifdef HILO_MT_EN
  input  logic [1:0]       mt,
`endif
  output logic [WIDTH-1:0] hlout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             mt_req;

  // Negating the most negative value wraps to itself, which is the unsigned magnitude we want.
  assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;

`ifdef HILO_MT_EN
  assign mt_req = mt[MF_ACTIVE];
`else
  assign mt_req = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_in    (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_out   (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            lo_d   = {WIDTH{DIV0_LO_BIT}};
            hi_d   = dividend;
            done_d = 1'b1;
          end else begin
            rem_d     = '0;
            quo_d     = dividend_abs;
            div_d     = divisor_abs;
            qneg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d    = dividend[WIDTH-1];
            counter_d = '0;
            state_d   = CALC;
          end
        end
`ifdef HILO_MT_EN
        else if (mt[MF_ACTIVE]) begin
          if (mt[MF_HI]) hi_d = dividend;
          else           lo_d = dividend;
        end
`endif
      end
      CALC: begin
        rem_d     = step_rem;
        quo_d     = step_quo;
        counter_d = counter_q + CNT_W'(1);
        if (counter_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign hlout     = mf[MF_HI] ? hi_q : lo_q;
  assign stall_req = busy & (mf[MF_ACTIVE] | start | mt_req);

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit; expected values are hand-computed constants.
module tb_hilo_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  mf;
`ifdef HILO_MT_EN
  logic [1:0]  mt;
`endif
  logic [31:0] hlout;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_req;

  int total;
  int bad;

  logic [31:0] model_hi;
  logic [31:0] model_lo;

  hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .mf        (mf),
`ifdef HILO_MT_EN
    .mt        (mt),
`endif
    .hlout     (hlout),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] mfv);
    start    = st;
    dividend = a;
    divisor  = b;
    mf       = mfv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full divide from start to done pulse with latency and hold checks along the way.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    applyStimulus(1'b1, a, b, 2'b00);
    tick();
    start = 1'b0;
    checkOutput({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    repeat (32) tick();
    checkOutput({tag, "_busy_e32"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, "_done_e32"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_lo_hold"}, lo, model_lo);
    tick();
    checkOutput({tag, "_lo"}, lo, exp_lo);
    checkOutput({tag, "_hi"}, hi, exp_hi);
    checkOutput({tag, "_done_e33"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_busy_e33"}, {31'd0, busy}, 32'd0);
    model_lo = exp_lo;
    model_hi = exp_hi;
    tick();
    checkOutput({tag, "_done_e34"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset    = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
`ifdef HILO_MT_EN
    mt = 2'b00;
`endif
    repeat (2) tick();
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    tick();

    run_div("d7_2", 32'd7, 32'd2, 32'd3, 32'd1);
    run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("d7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    // Divide by zero completes in one edge without leaving IDLE.
    applyStimulus(1'b1, 32'd5, 32'd0, 2'b00);
    checkOutput("dz_stall_idle", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0;
    checkOutput("dz_lo", lo, 32'hFFFF_FFFF);
    checkOutput("dz_hi", hi, 32'd5);
    checkOutput("dz_done", {31'd0, done}, 32'd1);
    checkOutput("dz_busy", {31'd0, busy}, 32'd0);
    model_lo = 32'hFFFF_FFFF;
    model_hi = 32'd5;
    tick();
    checkOutput("dz_done_clr", {31'd0, done}, 32'd0);

    mf = 2'b10;
    #1;
    checkOutput("mf_lo_idle", hlout, 32'hFFFF_FFFF);
    checkOutput("mf_idle_nostall", {31'd0, stall_req}, 32'd0);
    mf = 2'b11;
    #1;
    checkOutput("mf_hi_idle", hlout, 32'd5);
    mf = 2'b00;

    // Move-from HI while busy: stall until the result lands, then the new HI is visible.
    applyStimulus(1'b1, 32'd100, 32'd7, 2'b00);
    tick();
    start = 1'b0;
    repeat (9) tick();
    mf = 2'b11;
    #1;
    checkOutput("mfb_stall_c10", {31'd0, stall_req}, 32'd1);
    checkOutput("mfb_stale", hlout, 32'd5);
    repeat (23) tick();
    checkOutput("mfb_stall_e32", {31'd0, stall_req}, 32'd1);
    tick();
    checkOutput("mfb_stall_e33", {31'd0, stall_req}, 32'd0);
    checkOutput("mfb_hlout", hlout, 32'd2);
    checkOutput("mfb_lo", lo, 32'd14);
    model_lo = 32'd14;
    model_hi = 32'd2;
    mf = 2'b00;
    tick();

    // Second start while busy is ignored.
    applyStimulus(1'b1, 32'd20, 32'd3, 2'b00);
    tick();
    start = 1'b0;
    repeat (5) tick();
    applyStimulus(1'b1, 32'd9, 32'd4, 2'b00);
    #1;
    checkOutput("ss_stall", {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0;
    repeat (26) tick();
    checkOutput("ss_lo_hold", lo, 32'd14);
    tick();
    checkOutput("ss_lo", lo, 32'd6);
    checkOutput("ss_hi", hi, 32'd2);
    checkOutput("ss_done", {31'd0, done}, 32'd1);
    tick();
    checkOutput("ss_no_restart", {31'd0, busy}, 32'd0);
    model_lo = 32'd6;
    model_hi = 32'd2;

    // Asynchronous reset in the middle of a divide.
    applyStimulus(1'b1, 32'd100, 32'd7, 2'b00);
    tick();
    start = 1'b0;
    repeat (12) tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr_hi", hi, 32'd0);
    checkOutput("mr_lo", lo, 32'd0);
    checkOutput("mr_busy", {31'd0, busy}, 32'd0);
    checkOutput("mr_done", {31'd0, done}, 32'd0);
    #2;
    reset = 1'b0;
    model_lo = 32'd0;
    model_hi = 32'd0;
    tick();
    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);

`ifdef HILO_MT_EN
    applyStimulus(1'b0, 32'h0000_1234, 32'd0, 2'b00);
    mt = 2'b10;
    tick();
    mt = 2'b00;
    checkOutput("mt_lo", lo, 32'h0000_1234);
    checkOutput("mt_hi_keep", hi, 32'd2);
    applyStimulus(1'b0, 32'h0000_0055, 32'd0, 2'b00);
    mt = 2'b11;
    tick();
    mt = 2'b00;
    checkOutput("mt_hi", hi, 32'h0000_0055);
    model_lo = 32'h0000_1234;
    model_hi = 32'h0000_0055;

    applyStimulus(1'b1, 32'd7, 32'd2, 2'b00);
    tick();
    start = 1'b0;
    repeat (3) tick();
    dividend = 32'h0000_ABCD;
    mt = 2'b10;
    #1;
    checkOutput("mtb_stall", {31'd0, stall_req}, 32'd1);
    tick();
    mt = 2'b00;
    checkOutput("mtb_lo_hold", lo, 32'h0000_1234);
    repeat (29) tick();
    checkOutput("mtb_lo", lo, 32'd3);
    checkOutput("mtb_hi", hi, 32'd1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle responder for the execute-stage divide request (div control bit plus SrcA/SrcB operands) and mfhi/mflo reads.
- Replaces the single-cycle HI/LO path with a radix-2 restoring signed divider that owns the HI and LO registers.
- Raises a stall request to the hazard unit while a move-from would read an unfinished result.
- Sits in the E stage beside the ALU; the hlout result feeds the HI/LO select mux ahead of the shifter mux.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  divide request (divE); sampled only in IDLE.
- dividend  input  WIDTH  SrcAE (rs).
- divisor  input  WIDTH  SrcBE (rt).
- mf  input  2  mf[1]=move-from active; mf[0]=1 selects HI, 0 selects LO.
- hlout  output  WIDTH  combinational: mf[0] ? hi : lo.
- hi  output  WIDTH  remainder register.
- lo  output  WIDTH  quotient register.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the cycle after hi/lo update.
- stall_req  output  1  busy & (mf[1] | start).

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, done=0, counter=0. Internal remainder, quotient and sign flags are cleared. An in-flight divide is discarded.
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor!=0:
  - latch |dividend| and |divisor|
  - qneg = sign(dividend) XOR sign(divisor); rneg = sign(dividend)
  - counter=0 -> CALC
- IDLE, start=1, divisor==0: on the next edge lo=all-ones, hi=dividend, done=1. Stay in IDLE. Latency 1.
- CALC, one iteration per edge:
  - rem = {rem[WIDTH-2:0], q[WIDTH-1]}; q <<= 1
  - if rem >= |divisor|: rem -= |divisor|, q[0]=1
  - counter++; after WIDTH iterations (counter==WIDTH-1 on that edge) -> FIX.
- FIX:
  - lo = qneg ? -q : q; hi = rneg ? -rem : rem
  - done=1 on that edge; -> IDLE
- Latency: start sampled at edge 0; hi/lo written at edge WIDTH+1 (33 for WIDTH=32); done high for the cycle after edge WIDTH+1.
- Arithmetic:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Magnitude of 0x80000000 is taken as unsigned 0x80000000 (WIDTH-bit two's-complement wrap).
  - 0x80000000 / -1 yields lo=0x80000000, hi=0 (wraps; no trap).
- start while busy: ignored (no restart, no queue); stall_req=1 holds the pipeline so the initiator re-presents it.
- hi/lo hold their previous values throughout CALC; a move-from while busy asserts stall_req and hlout shows stale data, which the stall makes harmless.
- done is 0 in every cycle not immediately following a result write.

Optional Feature:
- Macro HILO_MT_EN.
- Defined: adds input mt[1:0] (mt[1]=write active, mt[0]=1 selects HI).
  - In IDLE, an mt write copies dividend into the selected register on the next edge.
  - If start and mt are both asserted, start wins and mt is dropped.
  - When busy, mt asserts stall_req and is not applied.
- Undefined: no mt port; hi/lo are written only by divide completion and reset.

Decomposition:
- Package hilo_pkg:
  - state enum (IDLE, CALC, FIX)
  - MF_ACTIVE/MF_HI bit indices
  - default WIDTH
  - divide-by-zero LO constant (all-ones)
- One natural sub-module, div_step: combinational single restoring iteration (rem_in, q_in, divisor -> rem_out, q_out). It is instantiated once and the FSM iterates it.

Test Plan:
- 7/2: start at edge 0 -> edge 33 lo=3, hi=1; done=1 for one cycle; busy=1 for cycles 1..33.
- -7/2: -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 7/-2 -> lo=0xFFFFFFFD, hi=1.
- 0x80000000/0xFFFFFFFF: -> lo=0x80000000, hi=0. 5/0 -> one edge later lo=0xFFFFFFFF, hi=5, done=1, busy never set.
- Busy-state stalls:
  - mf=2'b11 at cycle 10 -> stall_req=1 until IDLE, then hlout=hi of the new result.
  - Second start at cycle 5 -> ignored; the first result is unchanged.
- Mid-operation reset: reset asserted asynchronously at cycle 12 of 100/7 -> immediately hi=lo=0, busy=0, done=0. A fresh 100/7 afterwards -> lo=14, hi=2.
- With HILO_MT_EN: mt=2'b10, dividend=0x1234 in IDLE -> lo=0x1234 next edge. mt during busy -> stall_req=1, lo unchanged until completion.
